ps2_scan_decoder: RTL and testbench
===================================

# ps2_scan_decoder

Receives PS/2 keyboard frames on the raw `ps2_clk`/`ps2_data` pins and deserializes the 11-bit frames. It translates Set-2 scan codes into the 10-bit key codes consumed by the text-writer stage: letters become 1..26, and break, Enter and Backspace become dedicated codes. It sits directly upstream of the writer and drives its `teclado`/`done` inputs, one `done` pulse per received byte.

## Interface
- `TIMEOUT_CYCLES`, 50000: number of `clk` cycles without a PS/2 falling edge before a partial frame is abandoned.
- `SYNC_STAGES`, 2: flip-flop stages on each PS/2 input (minimum 2).
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset, synchronous, active-high.
- `ps2_clk`  in  1  raw PS/2 clock pin, asynchronous.
- `ps2_data`  in  1  raw PS/2 data pin, asynchronous.
- `teclado`  out  10  translated key code; held between pulses.
- `done`  out  1  one-cycle strobe: `teclado` is new this cycle.
- `frame_err`  out  1  one-cycle strobe: a frame was dropped (bad start, stop, parity or timeout).

## Operation
- **Input conditioning.** Both pins pass through `SYNC_STAGES` flops. A falling edge is synced previous = 1 and current = 0, producing a one-cycle `fall` pulse. Data is sampled on `fall`.
- **FSM states:**
  - IDLE: on `fall` with data 0 (start bit), go to DATA and clear the bit counter. On `fall` with data 1, stay in IDLE; no error.
  - DATA: on each `fall`, shift data into bit[7:0], LSB first. After the 8th bit, go to PARITY.
  - PARITY: on `fall`, capture the parity bit and go to STOP.
  - STOP: on `fall`, check the frame. It is valid when stop = 1 and the parity check passes (see Configuration). Valid → TRANSLATE. Invalid → pulse `frame_err` and return to IDLE.
  - TRANSLATE: one cycle. Register `teclado`, pulse `done`, return to IDLE.
- **Timeout.** A counter resets on every `fall` and counts in every non-IDLE state. When it reaches `TIMEOUT_CYCLES-1`, pulse `frame_err`, go to IDLE and discard the partial byte.
- **Translation of byte b:**
  - Letters map to 1..26: A 1C, B 32, C 21, D 23, E 24, F 2B, G 34, H 33, I 43, J 3B, K 42, L 4B, M 3A, N 31, O 44, P 4D, Q 15, R 2D, S 1B, T 2C, U 3C, V 2A, W 1D, X 22, Y 35, Z 1A.
  - F0 (break prefix) → 0x0F0.
  - 5A (Enter) → 0x0C0.
  - 66 (Backspace) → 0x108.
  - Any other byte, including the E0 extended prefix → {2'b10, b}. This is always ≥ 0x200, so the writer treats it as non-printing.
- The translator is stateless. The writer owns release-ignore behaviour, so the byte after F0 is translated normally.

## Timing
- **Reset values:** `teclado` = 0, `done` = 0, `frame_err` = 0, FSM = IDLE, shift register = 0, timeout counter = 0, synchronizer flops = 1 (line idle-high).
- **Latency:** let `fall` for the stop bit be asserted in cycle N. Then `done` is high in cycle N+1 with `teclado` valid, and `done` is low in N+2. In cycles where `done` is not pulsed, `teclado` holds its value.
- The pin-to-`fall` delay is `SYNC_STAGES`+1 cycles.
- Back-to-back frames: the next start bit is accepted from the cycle after TRANSLATE. PS/2 bit periods of ≥ 60 µs guarantee no overlap at any clk ≥ 1 MHz.
- `done` and `frame_err` are never high in the same cycle.
- `rst` asserted mid-frame: the next cycle is in IDLE, no pulses are generated, and the partial byte is lost.
- A timeout and a `fall` in the same cycle: the `fall` takes priority and the counter clears.
- The timeout counter is $clog2(TIMEOUT_CYCLES) bits wide and saturates; it never wraps.

## Configuration
- Macro: `PS2_PARITY_CHECK_EN`.
- Defined: the frame is valid only when ^{b, parity} = 1 (odd parity). A failure pulses `frame_err` and produces no `done`.
- Undefined: the parity bit is sampled and ignored. Only the stop bit and timeout cause `frame_err`.

## Test plan
- **Letter:** send frame 0x1C with correct odd parity → exactly one `done`, `teclado` = 0x001, `frame_err` never high.
- **Special codes:** send F0 then 1C → `done` with 0x0F0, then `done` with 0x001. Send 5A → 0x0C0. Send 66 → 0x108. Send 76 (Esc) → 0x276.
- **Bad parity:** send 0x24 with the parity bit inverted.
  - Macro defined: one `frame_err`, no `done`, `teclado` unchanged.
  - Macro undefined: `done` with 0x005.
- **Bad stop:** send 0x15 with stop bit = 0 → `frame_err`, no `done`. A following good 0x1A frame → `done` with 0x01A.
- **Timeout:** with `TIMEOUT_CYCLES` = 100, send the start bit plus 3 data bits, then hold the clock high for 100 cycles → one `frame_err`. A following good 0x4D frame → `done` with 0x010.
- **Reset mid-frame:** pulse `rst` after 5 data bits → no `done` or `frame_err`. The next full 0x2B frame → `done` with 0x006.

Source files
------------

// File: rtl/ps2_scan_decoder.sv
// PS/2 keyboard receiver that turns Set-2 scan codes into writer key codes.
// Optional odd-parity checking is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_scan_decoder #(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [9:0] teclado,
    output logic       done,
    output logic       frame_err
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_TRANSLATE
    } state_t;

    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
    logic                   clk_prev_q, clk_prev_d;
    logic                   fall_q, fall_d;
    logic                   data_smp_q, data_smp_d;
    state_t                 state_q, state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic [TW-1:0]          tmo_q, tmo_d;
    logic [9:0]             teclado_q, teclado_d;
    logic                   done_q, done_d;
    logic                   frame_err_q, frame_err_d;
    logic                   frame_ok;
`ifdef PS2_PARITY_CHECK_EN
    logic                   parity_q, parity_d;
`endif

    function automatic logic [9:0] translate(input logic [7:0] b);
        logic [9:0] code;
        case (b)
            8'h1C: code = 10'd1;
            8'h32: code = 10'd2;
            8'h21: code = 10'd3;
            8'h23: code = 10'd4;
            8'h24: code = 10'd5;
            8'h2B: code = 10'd6;
            8'h34: code = 10'd7;
            8'h33: code = 10'd8;
            8'h43: code = 10'd9;
            8'h3B: code = 10'd10;
            8'h42: code = 10'd11;
            8'h4B: code = 10'd12;
            8'h3A: code = 10'd13;
            8'h31: code = 10'd14;
            8'h44: code = 10'd15;
            8'h4D: code = 10'd16;
            8'h15: code = 10'd17;
            8'h2D: code = 10'd18;
            8'h1B: code = 10'd19;
            8'h2C: code = 10'd20;
            8'h3C: code = 10'd21;
            8'h2A: code = 10'd22;
            8'h1D: code = 10'd23;
            8'h22: code = 10'd24;
            8'h35: code = 10'd25;
            8'h1A: code = 10'd26;
            8'hF0: code = 10'h0F0;
            8'h5A: code = 10'h0C0;
            8'h66: code = 10'h108;
            default: code = {2'b10, b};
        endcase
        return code;
    endfunction

    // Sampled data is registered alongside fall so both refer to the same PS/2 edge.
    always_comb begin
        clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
        data_sync_d = {data_sync_q[SYNC_STAGES-2:0], ps2_data};
        clk_prev_d  = clk_sync_q[SYNC_STAGES-1];
        fall_d      = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
        data_smp_d  = data_sync_q[SYNC_STAGES-1];
    end

`ifdef PS2_PARITY_CHECK_EN
    assign frame_ok = data_smp_q & (^{shift_q, parity_q});
`else
    assign frame_ok = data_smp_q;
`endif

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        teclado_d   = teclado_q;
        done_d      = 1'b0;
        frame_err_d = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
        parity_d    = parity_q;
`endif

        if (state_q == S_IDLE || fall_q) begin
            tmo_d = '0;
        end else if (tmo_q != TMO_LAST) begin
            tmo_d = tmo_q + TW'(1);
        end else begin
            tmo_d = tmo_q;
        end

        case (state_q)
            S_IDLE: begin
                if (fall_q && !data_smp_q) begin
                    state_d   = S_DATA;
                    bit_cnt_d = 3'd0;
                end
            end
            S_DATA: begin
                if (fall_q) begin
                    shift_d   = {data_smp_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_PARITY;
                    end
                end
            end
            S_PARITY: begin
                if (fall_q) begin
`ifdef PS2_PARITY_CHECK_EN
                    parity_d = data_smp_q;
`endif
                    state_d  = S_STOP;
                end
            end
            S_STOP: begin
                if (fall_q) begin
                    if (frame_ok) begin
                        teclado_d = translate(shift_q);
                        done_d    = 1'b1;
                        state_d   = S_TRANSLATE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_IDLE;
                    end
                end
            end
            S_TRANSLATE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A stalled partial frame is abandoned; a fall in the same cycle wins.
        if (state_q != S_IDLE && !fall_q && tmo_q == TMO_LAST) begin
            state_d     = S_IDLE;
            done_d      = 1'b0;
            frame_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            clk_prev_q  <= 1'b1;
            fall_q      <= 1'b0;
            data_smp_q  <= 1'b1;
            state_q     <= S_IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'd0;
            tmo_q       <= '0;
            teclado_q   <= 10'd0;
            done_q      <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            clk_prev_q  <= clk_prev_d;
            fall_q      <= fall_d;
            data_smp_q  <= data_smp_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            tmo_q       <= tmo_d;
            teclado_q   <= teclado_d;
            done_q      <= done_d;
            frame_err_q <= frame_err_d;
`ifdef PS2_PARITY_CHECK_EN
            parity_q    <= parity_d;
`endif
        end
    end

    assign teclado   = teclado_q;
    assign done      = done_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Bench for ps2_scan_decoder: drives PS/2 frames on the pins and checks the
// translated key codes, done/frame_err strobes and their cycle timing.
module tb_ps2_scan_decoder;

    localparam int T    = 100;
    localparam int S    = 2;
    localparam int HALF = 10;

    localparam logic [7:0] LETTERS [26] = '{
        8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
        8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
        8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A
    };

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       ps2_clk  = 1'b1;
    logic       ps2_data = 1'b1;
    logic [9:0] teclado;
    logic       done;
    logic       frame_err;

    int         cyc           = 0;
    int         tests         = 0;
    int         fails         = 0;
    int         exp_done_cyc  = -1;
    int         exp_err_cyc   = -1;
    int         rst_cyc       = -1;
    logic [9:0] exp_code      = 10'd0;
    logic [9:0] model_teclado = 10'd0;
    int         done_cnt      = 0;
    int         err_cnt       = 0;
    int         base_done     = 0;
    int         base_err      = 0;
    bit         chk_en        = 1'b0;

    ps2_scan_decoder #(
        .TIMEOUT_CYCLES(T),
        .SYNC_STAGES   (S)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .teclado  (teclado),
        .done     (done),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [9:0] modelTranslate(input logic [7:0] b);
        for (int i = 0; i < 26; i++) begin
            if (LETTERS[i] == b) return 10'(i + 1);
        end
        if (b == 8'hF0) return 10'h0F0;
        if (b == 8'h5A) return 10'h0C0;
        if (b == 8'h66) return 10'h108;
        return 10'h200 + 10'(b);
    endfunction

    task automatic checkOutput(input string name, input logic [9:0] act, input logic [9:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Every cycle: strobes must land exactly on the predicted cycles and teclado must hold otherwise.
    always @(negedge clk) begin
        if (chk_en) begin
            if (cyc == rst_cyc) model_teclado = 10'd0;
            if (cyc == exp_done_cyc) model_teclado = exp_code;
            checkOutput("done_strobe", {9'd0, done}, {9'd0, cyc == exp_done_cyc});
            checkOutput("err_strobe", {9'd0, frame_err}, {9'd0, cyc == exp_err_cyc});
            checkOutput("teclado_hold", teclado, model_teclado);
        end
        if (done) done_cnt++;
        if (frame_err) err_cnt++;
    end

    // Sends the first nbits of an 11-bit frame; the stop-bit edge schedules the expected outcome.
    task automatic applyStimulus(input logic [7:0] b, input logic bad_par, input logic stop_val,
                                 input int nbits, output int last_fall);
        logic [10:0] fr;
        logic        par;
        logic        ok;
        par = (~^b) ^ bad_par;
        fr  = {stop_val, par, b, 1'b0};
`ifdef PS2_PARITY_CHECK_EN
        ok = stop_val && !bad_par;
`else
        ok = stop_val;
`endif
        last_fall = -1;
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            ps2_data = fr[i];
            repeat (HALF) @(negedge clk);
            ps2_clk   = 1'b0;
            last_fall = cyc;
            if (i == 10) begin
                if (ok) begin
                    exp_code     = modelTranslate(b);
                    exp_done_cyc = cyc + S + 2;
                end else begin
                    exp_err_cyc = cyc + S + 2;
                end
            end
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
        @(negedge clk);
        ps2_data = 1'b1;
    endtask

    task automatic frameCheck(input string name, input logic [9:0] exp_tec, input int exp_d, input int exp_e);
        repeat (20) @(negedge clk);
        checkOutput({name, "_code"}, teclado, exp_tec);
        checkOutput({name, "_dones"}, 10'(done_cnt - base_done), 10'(exp_d));
        checkOutput({name, "_errs"}, 10'(err_cnt - base_err), 10'(exp_e));
        base_done = done_cnt;
        base_err  = err_cnt;
    endtask

    task automatic sendFrame(input string name, input logic [7:0] b, input logic bad_par,
                             input logic stop_val, input logic [9:0] exp_tec, input int exp_d, input int exp_e);
        int lf;
        applyStimulus(b, bad_par, stop_val, 11, lf);
        frameCheck(name, exp_tec, exp_d, exp_e);
    endtask

    initial begin
        int         lf;
        logic [9:0] after_par;

        repeat (3) @(negedge clk);
        checkOutput("reset_teclado", teclado, 10'h000);
        checkOutput("reset_done", {9'd0, done}, 10'd0);
        checkOutput("reset_err", {9'd0, frame_err}, 10'd0);
        rst = 1'b0;
        chk_en = 1'b1;
        repeat (10) @(negedge clk);

        sendFrame("letter_a", 8'h1C, 1'b0, 1'b1, 10'h001, 1, 0);
        sendFrame("break", 8'hF0, 1'b0, 1'b1, 10'h0F0, 1, 0);
        sendFrame("after_break", 8'h1C, 1'b0, 1'b1, 10'h001, 1, 0);
        sendFrame("enter", 8'h5A, 1'b0, 1'b1, 10'h0C0, 1, 0);
        sendFrame("backspace", 8'h66, 1'b0, 1'b1, 10'h108, 1, 0);
        sendFrame("escape", 8'h76, 1'b0, 1'b1, 10'h276, 1, 0);
        sendFrame("extended", 8'hE0, 1'b0, 1'b1, 10'h2E0, 1, 0);

`ifdef PS2_PARITY_CHECK_EN
        sendFrame("bad_parity", 8'h24, 1'b1, 1'b1, 10'h2E0, 0, 1);
        after_par = 10'h2E0;
`else
        sendFrame("bad_parity", 8'h24, 1'b1, 1'b1, 10'h005, 1, 0);
        after_par = 10'h005;
`endif

        sendFrame("bad_stop", 8'h15, 1'b0, 1'b0, after_par, 0, 1);
        sendFrame("after_bad_stop", 8'h1A, 1'b0, 1'b1, 10'h01A, 1, 0);

        applyStimulus(8'h4D, 1'b0, 1'b1, 4, lf);
        exp_err_cyc = lf + S + T + 2;
        repeat (150) @(negedge clk);
        frameCheck("timeout", 10'h01A, 0, 1);
        sendFrame("after_timeout", 8'h4D, 1'b0, 1'b1, 10'h010, 1, 0);

        applyStimulus(8'h2B, 1'b0, 1'b1, 6, lf);
        @(negedge clk);
        rst     = 1'b1;
        rst_cyc = cyc + 1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (150) @(negedge clk);
        frameCheck("mid_reset", 10'h000, 0, 0);
        sendFrame("after_reset", 8'h2B, 1'b0, 1'b1, 10'h006, 1, 0);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
